// File: rtl/cell_mem_arbiter_if.sv
// Bundle of the force/motion client handshakes and the single-port memory pins
// seen by one cell_mem_arbiter instance.
interface cell_mem_arbiter_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_gnt;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_gnt;
  logic                  motion_start;
  logic                  motion_active;
  logic                  motion_done;
  logic                  addr_err;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_q;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, motion_start, mem_q,
    output rd_gnt, rd_data, rd_valid, wr_gnt, motion_active, motion_done,
           addr_err, mem_address, mem_data, mem_rden, mem_wren
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, motion_start, mem_q,
    input  rd_gnt, rd_data, rd_valid, wr_gnt, motion_active, motion_done,
           addr_err, mem_address, mem_data, mem_rden, mem_wren
  );
endinterface

// File: rtl/cell_mem_arbiter.sv
// Single-port cell position memory arbiter: FORCE-phase reads, a two-cycle DRAIN
// of in-flight reads, then MOTION-phase write-back of PARTICLE_NUM words.
module cell_mem_arbiter #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic              clk,
  input  logic              rst,
  cell_mem_arbiter_if.slave bus
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PARTICLE_NUM - 1);

  typedef enum logic [1:0] {
    ST_FORCE  = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_MOTION = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  pending_q, pending_d;
  logic                  drain_q, drain_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic                  done_d;
  logic                  rd_gnt_s, wr_gnt_s, rd_ok_s, wr_ok_s;
  logic [ADDR_WIDTH-1:0] mem_address_q;
  logic [DATA_WIDTH-1:0] mem_data_q;
  logic                  mem_rden_q, mem_wren_q;
  logic                  p1_valid_q, p1_oor_q, rd_valid_q, rd_oor_q;
  logic [DATA_WIDTH-1:0] rd_hold_q, rd_data_s;
  logic                  motion_active_q, motion_done_q, addr_err_q;

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, addr} < CNT_W'(PARTICLE_NUM);
  endfunction

  assign rd_ok_s = addr_in_range(bus.rd_addr);
  assign wr_ok_s = addr_in_range(bus.wr_addr);

  // Phase sequencing and grant decode; grants are suppressed while rst is held.
  always_comb begin
    rd_gnt_s  = 1'b0;
    wr_gnt_s  = 1'b0;
    state_d   = state_q;
    pending_d = pending_q;
    drain_d   = drain_q;
    wr_cnt_d  = wr_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      ST_FORCE: begin
        rd_gnt_s = bus.rd_req & ~pending_q & ~rst;
        if (bus.motion_start | pending_q) begin
          pending_d = 1'b1;
          drain_d   = 1'b0;
          state_d   = ST_DRAIN;
        end else begin
          pending_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (drain_q && !p1_valid_q) begin
          state_d   = ST_MOTION;
          pending_d = 1'b0;
        end else begin
          drain_d = 1'b1;
        end
      end
      ST_MOTION: begin
        wr_gnt_s = bus.wr_req & ~rst;
        if (wr_gnt_s) begin
          if (wr_cnt_q == LAST_CNT) begin
            wr_cnt_d = '0;
            state_d  = ST_FORCE;
            done_d   = 1'b1;
          end else begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
          end
        end else begin
          wr_cnt_d = wr_cnt_q;
        end
      end
      default: begin
        state_d = ST_FORCE;
      end
    endcase
  end

  // State, memory strobes and the two-stage read-return tracker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_FORCE;
      pending_q       <= 1'b0;
      drain_q         <= 1'b0;
      wr_cnt_q        <= '0;
      mem_address_q   <= '0;
      mem_data_q      <= '0;
      mem_rden_q      <= 1'b0;
      mem_wren_q      <= 1'b0;
      p1_valid_q      <= 1'b0;
      p1_oor_q        <= 1'b0;
      rd_valid_q      <= 1'b0;
      rd_oor_q        <= 1'b0;
      rd_hold_q       <= '0;
      motion_active_q <= 1'b0;
      motion_done_q   <= 1'b0;
      addr_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      drain_q         <= drain_d;
      wr_cnt_q        <= wr_cnt_d;
      motion_active_q <= (state_d == ST_MOTION);
      motion_done_q   <= done_d;
      mem_rden_q      <= rd_gnt_s & rd_ok_s;
      mem_wren_q      <= wr_gnt_s & wr_ok_s;
      // Out-of-range grants leave address/data untouched and raise the sticky error.
      if (rd_gnt_s && rd_ok_s) begin
        mem_address_q <= bus.rd_addr;
      end else if (wr_gnt_s && wr_ok_s) begin
        mem_address_q <= bus.wr_addr;
        mem_data_q    <= bus.wr_data;
      end
      if ((rd_gnt_s && !rd_ok_s) || (wr_gnt_s && !wr_ok_s)) begin
        addr_err_q <= 1'b1;
      end
      p1_valid_q <= rd_gnt_s;
      p1_oor_q   <= ~rd_ok_s;
      rd_valid_q <= p1_valid_q;
      rd_oor_q   <= p1_oor_q;
      if (rd_valid_q) begin
        rd_hold_q <= rd_data_s;
      end
    end
  end

  // mem_q only becomes valid in the return cycle, so it is steered straight through.
  assign rd_data_s = rd_valid_q ? (rd_oor_q ? '0 : bus.mem_q) : rd_hold_q;

  assign bus.rd_gnt        = rd_gnt_s;
  assign bus.wr_gnt        = wr_gnt_s;
  assign bus.rd_data       = rd_data_s;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.motion_active = motion_active_q;
  assign bus.motion_done   = motion_done_q;
  assign bus.addr_err      = addr_err_q;
  assign bus.mem_address   = mem_address_q;
  assign bus.mem_data      = mem_data_q;
  assign bus.mem_rden      = mem_rden_q;
  assign bus.mem_wren      = mem_wren_q;

endmodule

// File: tb/tb_cell_mem_arbiter.sv
// Self-checking bench for cell_mem_arbiter: directed scenarios plus random traffic,
// compared each cycle against a phase/queue level reference model.
module tb_cell_mem_arbiter;
  localparam int DW = 96;
  localparam int PN = 220;
  localparam int AW = 8;
  localparam int P_FORCE  = 0;
  localparam int P_DRAIN  = 1;
  localparam int P_MOTION = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cell_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  cell_mem_arbiter #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Memory device: 1-cycle registered read.
  logic [DW-1:0] ram [0:PN-1];
  logic [DW-1:0] ram_q;
  assign bus.mem_q = ram_q;
  always @(posedge clk) begin
    if (bus.mem_rden && bus.mem_address < PN) ram_q <= ram[bus.mem_address];
    if (bus.mem_wren && bus.mem_address < PN) ram[bus.mem_address] <= bus.mem_data;
  end

  function automatic logic [DW-1:0] init_word(int i);
    return {32'(i + 32'h300), 32'(i + 32'h200), 32'(i + 32'h100)};
  endfunction

  task automatic chk(string name, logic [DW-1:0] got, logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // Reference model state: phase, write count, shadow memory, queue of read returns.
  typedef struct { int due; logic [DW-1:0] data; } rd_t;
  rd_t           rdq [$];
  logic [DW-1:0] shadow [0:PN-1];
  int            phase = P_FORCE;
  int            drain_left = 0;
  int            wcount = 0;
  bit            m_err = 0, m_done = 0;
  bit            e_rden = 0, e_wren = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_data = '0, last_rd = '0;
  bit            wb_pend = 0;
  int            wb_addr = 0;
  logic [DW-1:0] wb_data = '0;

  task automatic check_outputs(bit g_rd, bit g_wr, bit vld, logic [DW-1:0] rdd, bit act,
                               bit done, bit err, bit rden, bit wren,
                               logic [AW-1:0] addr, logic [DW-1:0] data);
    chk("rd_gnt", DW'(bus.rd_gnt), DW'(g_rd));
    chk("wr_gnt", DW'(bus.wr_gnt), DW'(g_wr));
    chk("rd_valid", DW'(bus.rd_valid), DW'(vld));
    chk("rd_data", bus.rd_data, rdd);
    chk("motion_active", DW'(bus.motion_active), DW'(act));
    chk("motion_done", DW'(bus.motion_done), DW'(done));
    chk("addr_err", DW'(bus.addr_err), DW'(err));
    chk("mem_rden", DW'(bus.mem_rden), DW'(rden));
    chk("mem_wren", DW'(bus.mem_wren), DW'(wren));
    chk("mem_address", DW'(bus.mem_address), DW'(addr));
    chk("mem_data", bus.mem_data, data);
  endtask

  // Compare against the model on every falling edge, then advance the model.
  always @(negedge clk) begin
    bit g_rd, g_wr, vld;
    int ra, wa;
    cyc++;
    if (rst) begin
      check_outputs(0, 0, 0, '0, 0, 0, 0, 0, 0, '0, '0);
      phase = P_FORCE; drain_left = 0; wcount = 0; m_err = 0; m_done = 0;
      e_rden = 0; e_wren = 0; e_addr = '0; e_data = '0; last_rd = '0;
      wb_pend = 0; rdq.delete();
    end else begin
      if (wb_pend) shadow[wb_addr] = wb_data;
      wb_pend = 0;
      ra = int'(bus.rd_addr);
      wa = int'(bus.wr_addr);
      g_rd = bus.rd_req && phase == P_FORCE;
      g_wr = bus.wr_req && phase == P_MOTION;
      vld = rdq.size() > 0 && rdq[0].due == cyc;
      if (vld) begin
        last_rd = rdq[0].data;
        void'(rdq.pop_front());
      end
      check_outputs(g_rd, g_wr, vld, last_rd, phase == P_MOTION, m_done, m_err,
                    e_rden, e_wren, e_addr, e_data);
      m_done = 0; e_rden = 0; e_wren = 0;
      if (g_rd) begin
        rd_t r;
        r.due = cyc + 2;
        r.data = (ra < PN) ? shadow[ra] : '0;
        rdq.push_back(r);
        if (ra < PN) begin e_rden = 1; e_addr = bus.rd_addr; end
        else m_err = 1;
      end
      if (g_wr) begin
        if (wa < PN) begin
          e_wren = 1; e_addr = bus.wr_addr; e_data = bus.wr_data;
          wb_pend = 1; wb_addr = wa; wb_data = bus.wr_data;
        end else m_err = 1;
        wcount++;
      end
      if (phase == P_FORCE) begin
        if (bus.motion_start) begin phase = P_DRAIN; drain_left = 2; end
      end else if (phase == P_DRAIN) begin
        drain_left--;
        if (drain_left == 0) phase = P_MOTION;
      end else if (wcount == PN) begin
        phase = P_FORCE; wcount = 0; m_done = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_motion(output int lat);
    bus.motion_start = 1'b1;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.motion_active) break;
      lat++;
      step();
      bus.motion_start = 1'b0;
    end
    bus.motion_start = 1'b0;
    step();
  endtask

  task automatic run_writes(int n, int base, output int dones);
    dones = 0;
    for (int i = 0; i < n; i++) begin
      bus.wr_req  = 1'b1;
      bus.wr_addr = AW'(base + i);
      bus.wr_data = DW'((base + i) * 3);
      @(negedge clk);
      if (bus.motion_done) dones++;
      step();
    end
    bus.wr_req = 1'b0;
  endtask

  task automatic wait_valid(output logic [DW-1:0] got, output bit found);
    found = 0;
    got = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.rd_valid) begin
        got = bus.rd_data;
        found = 1;
        break;
      end
      step();
    end
    step();
  endtask

  initial begin
    int lat, dones, nvalid;
    bit found;
    logic [DW-1:0] got, first_w, last_w;
    rst = 1'b1;
    bus.rd_req = 1'b0; bus.rd_addr = '0; bus.wr_req = 1'b0; bus.wr_addr = '0;
    bus.wr_data = '0; bus.motion_start = 1'b0;
    ram_q = '0;
    for (int i = 0; i < PN; i++) begin
      ram[i] = init_word(i);
      shadow[i] = init_word(i);
    end
    step(); step();
    rst = 1'b0;

    // Back-to-back reads of words 0..4.
    nvalid = 0; first_w = '0; last_w = '0;
    for (int i = 0; i < 9; i++) begin
      bus.rd_req = (i < 5);
      bus.rd_addr = AW'(i);
      @(negedge clk);
      if (i < 5) chk("t1_rd_gnt", DW'(bus.rd_gnt), DW'(1));
      if (bus.rd_valid) begin
        if (nvalid == 0) first_w = bus.rd_data;
        last_w = bus.rd_data;
        nvalid++;
      end
      step();
    end
    chk("t1_valid_count", DW'(nvalid), DW'(5));
    chk("t1_word0", first_w, 96'h00000300_00000200_00000100);
    chk("t1_word4", last_w, 96'h00000304_00000204_00000104);

    // motion_start while reads are streaming.
    bus.rd_req = 1'b1; bus.rd_addr = AW'(5); bus.motion_start = 1'b1; lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) chk("t2_gnt_at_start", DW'(bus.rd_gnt), DW'(1));
      if (k == 1) chk("t2_gnt_blocked", DW'(bus.rd_gnt), DW'(0));
      if (bus.motion_active) break;
      lat++;
      step();
      bus.motion_start = 1'b0;
    end
    bus.rd_req = 1'b0;
    bus.motion_start = 1'b0;
    step();
    chk("t2_active_latency", DW'(lat), DW'(3));

    // Full write-back with data = addr*3, then readback of address 7.
    run_writes(PN, 0, dones);
    chk("t3_no_early_done", DW'(dones), DW'(0));
    @(negedge clk);
    chk("t3_done_pulse", DW'(bus.motion_done), DW'(1));
    chk("t3_back_to_force", DW'(bus.motion_active), DW'(0));
    step();
    @(negedge clk);
    chk("t3_done_single", DW'(bus.motion_done), DW'(0));
    bus.rd_req = 1'b1; bus.rd_addr = AW'(7);
    step();
    bus.rd_req = 1'b0;
    wait_valid(got, found);
    chk("t3_readback_seen", DW'(found), DW'(1));
    chk("t3_readback_7", got, 96'd21);

    // Out-of-range read.
    bus.rd_req = 1'b1; bus.rd_addr = AW'(230);
    @(negedge clk);
    chk("t4_oor_gnt", DW'(bus.rd_gnt), DW'(1));
    step();
    bus.rd_req = 1'b0;
    @(negedge clk);
    chk("t4_no_rden", DW'(bus.mem_rden), DW'(0));
    chk("t4_addr_err", DW'(bus.addr_err), DW'(1));
    step();
    wait_valid(got, found);
    chk("t4_oor_valid", DW'(found), DW'(1));
    chk("t4_oor_data", got, '0);

    // wr_req held through FORCE and DRAIN, 100 writes, then reset mid-MOTION.
    bus.wr_req = 1'b1; bus.wr_addr = AW'(3); bus.motion_start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_no_wr_gnt", DW'(bus.wr_gnt), DW'(0));
      chk("t6_no_wren", DW'(bus.mem_wren), DW'(0));
      step();
      bus.motion_start = 1'b0;
    end
    run_writes(100, 0, dones);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_active", DW'(bus.motion_active), DW'(0));
    chk("t5_rst_err", DW'(bus.addr_err), DW'(0));
    chk("t5_rst_wren", DW'(bus.mem_wren), DW'(0));
    step();
    rst = 1'b0;
    enter_motion(lat);
    chk("t5_active_latency", DW'(lat), DW'(3));
    run_writes(PN - 1, 0, dones);
    chk("t5_no_done_219", DW'(dones), DW'(0));
    run_writes(1, PN - 1, dones);
    @(negedge clk);
    chk("t5_done_after_220", DW'(bus.motion_done), DW'(1));
    step();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 799) == 0);
      bus.rd_req = ($urandom_range(0, 3) != 0);
      bus.rd_addr = AW'($urandom_range(0, 239));
      bus.wr_req = ($urandom_range(0, 3) != 0);
      bus.wr_addr = AW'($urandom_range(0, 239));
      bus.wr_data = {$urandom, $urandom, $urandom};
      bus.motion_start = ($urandom_range(0, 39) == 0);
      step();
    end
    rst = 1'b0; bus.rd_req = 1'b0; bus.wr_req = 1'b0; bus.motion_start = 1'b0;
    for (int k = 0; k < 4; k++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cell_mem_arbiter.md
Name: cell_mem_arbiter

Overview:
- Sequences access to one single-port cell position memory: 96-bit {posz, posy, posx} words, 220 words, 1-cycle read delay.
- Two phases share the one port:
  - FORCE: the force pipeline reads positions.
  - MOTION: the motion-update unit writes positions back.
- Guarantees no read/write collision on the single port and drains in-flight reads before write-back.
- Instantiated once per cell, between the per-cell memory and the force/motion-update logic in the RL top level.

Parameters:
DATA_WIDTH, 96, position word width {posz,posy,posx}
PARTICLE_NUM, 220, valid words in the cell memory; also the write count that ends a MOTION phase
ADDR_WIDTH, 8, memory address width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rd_req  in  1  force-pipeline read request
rd_addr  in  ADDR_WIDTH  read address
rd_gnt  out  1  read accepted this cycle (combinational)
rd_data  out  DATA_WIDTH  read data
rd_valid  out  1  rd_data valid
wr_req  in  1  motion-update write request
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
wr_gnt  out  1  write accepted this cycle (combinational)
motion_start  in  1  one-cycle pulse requesting the MOTION phase
motion_active  out  1  high while in MOTION
motion_done  out  1  one-cycle pulse when MOTION completes
addr_err  out  1  sticky: an out-of-range address was accepted
mem_address  out  ADDR_WIDTH  to memory address
mem_data  out  DATA_WIDTH  to memory data
mem_rden  out  1  to memory rden
mem_wren  out  1  to memory wren
mem_q  in  DATA_WIDTH  from memory q

Behaviour:
- Reset: state=FORCE; all of the following are 0:
  - mem_address, mem_data, mem_rden, mem_wren
  - rd_data, rd_valid
  - motion_active, motion_done, addr_err
  - pending flag, write counter
- Reset mid-operation aborts any phase. In-flight read results are discarded: rd_valid stays 0.
- States: FORCE, DRAIN, MOTION.
- FORCE:
  - rd_gnt = rd_req & ~pending. wr_gnt = 0.
  - motion_start sets pending. Pending blocks new read grants from the next cycle.
  - motion_start and rd_req in the same cycle: the read is granted.
  - Go to DRAIN when pending=1.
- DRAIN:
  - No grants.
  - Leave after 2 cycles, once the read pipeline is empty: go to MOTION and clear pending.
  - motion_start in DRAIN or MOTION is ignored.
- MOTION:
  - motion_active=1. wr_gnt = wr_req. rd_gnt = 0.
  - Each grant increments a write counter, width ADDR_WIDTH+1.
  - On the grant that makes the count equal PARTICLE_NUM:
    - the next cycle is FORCE;
    - motion_done pulses for one cycle, coincident with the first FORCE cycle;
    - the counter clears.
- Memory drive (registered): a grant in cycle T drives mem_* on the edge ending T:
  - read: mem_rden=1, mem_wren=0, mem_address=rd_addr;
  - write: mem_wren=1, mem_rden=0, mem_address=wr_addr, mem_data=wr_data.
- Without a grant: mem_rden=0, mem_wren=0; address and data hold their last value.
- Read latency: grant in cycle T gives rd_valid=1 and rd_data=mem_q in cycle T+2. Reads granted back-to-back return at one per cycle, in order.
- Out-of-range address (addr >= PARTICLE_NUM):
  - The request is still granted and addr_err sets (sticky until rst).
  - No memory strobe is issued.
  - A read still returns rd_valid in T+2 with rd_data=0.
  - A write still counts toward PARTICLE_NUM.
- rd_data holds its last value when rd_valid=0.

Test Plan:
- Reset, then rd_req=1, rd_addr=0..4 for 5 cycles -> rd_gnt=1 each cycle; mem_rden=1 with addresses 0..4 one cycle later; rd_valid=1 with rd_data=init words 0..4 two cycles after each grant.
- FORCE, rd_req held high, motion_start pulse at cycle 10 -> read granted at 10, none from 11; motion_active=1 at 13; last rd_valid at 12; no mem_wren before cycle 13.
- MOTION, wr_req high, wr_addr=0..219, wr_data=addr*3 -> 220 grants; motion_done pulses exactly once, on the cycle after the 220th grant; readback of address 7 returns 21.
- rd_addr=230 in FORCE -> rd_gnt=1, mem_rden stays 0, rd_valid=1 two cycles later with rd_data=0, addr_err=1 until rst.
- rst asserted mid-MOTION after 100 writes -> all outputs 0 immediately; state FORCE; a second motion_start requires the full 220 writes before motion_done.
- wr_req=1 during FORCE and DRAIN -> wr_gnt=0 and mem_wren=0 throughout.
